// File: rtl/booth_mult_ctrl.sv
// booth_mult_ctrl: radix-2 Booth sequencer driving the multiplicador datapath.
// Define MULT_CTRL_ABORT_EN to add an abort input that drops any run back to IDLE.
module booth_mult_ctrl #(
  parameter int N = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] Q_LSB,
`ifdef MULT_CTRL_ABORT_EN
  input  logic       abort,
`endif
  output logic [4:0] mult_control,
  output logic       busy,
  output logic       done
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CHECK,
    ADD,
    SHIFT,
    DONE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          op_q, op_d;

  logic load_a;
  logic load_b;
  logic load_add;
  logic shift_hq;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = LOAD;
      end
      LOAD: begin
        cnt_d   = CW'(N);
        state_d = CHECK;
      end
      CHECK: begin
        unique case (1'b1)
          (Q_LSB == 2'b01): begin
            op_d    = 1'b1;
            state_d = ADD;
          end
          (Q_LSB == 2'b10): begin
            op_d    = 1'b0;
            state_d = ADD;
          end
          default: state_d = SHIFT;
        endcase
      end
      ADD: begin
        state_d = SHIFT;
      end
      SHIFT: begin
        cnt_d   = cnt_q - CW'(1);
        state_d = (cnt_q == CW'(1)) ? DONE : CHECK;
      end
      DONE: begin
        // op is cleared on the way out so IDLE shows an all-zero bus
        state_d = IDLE;
        op_d    = 1'b0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        op_d    = 1'b0;
      end
    endcase
`ifdef MULT_CTRL_ABORT_EN
    if (abort && state_q != IDLE) begin
      state_d = IDLE;
      cnt_d   = '0;
      op_d    = 1'b0;
    end
`endif
  end

  always_comb begin
    load_a   = 1'b0;
    load_b   = 1'b0;
    load_add = 1'b0;
    shift_hq = 1'b0;
    busy     = 1'b1;
    done     = 1'b0;
    unique case (state_q)
      IDLE:    busy = 1'b0;
      LOAD: begin
        load_a = 1'b1;
        load_b = 1'b1;
      end
      CHECK:   ;
      ADD:     load_add = 1'b1;
      SHIFT:   shift_hq = 1'b1;
      DONE:    done = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  assign mult_control = {load_a, load_b, load_add, shift_hq, op_q};

endmodule

// File: tb/tb_booth_mult_ctrl.sv
// tb_booth_mult_ctrl: closed-loop bench with a behavioural Booth datapath
// and a per-run expected-trace model derived from the multiplier bits.
module tb_booth_mult_ctrl;

  localparam int N = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [1:0] q_lsb;
  logic [4:0] mult_control;
  logic       busy;
  logic       done;
`ifdef MULT_CTRL_ABORT_EN
  logic       abort = 1'b0;
`endif

  booth_mult_ctrl #(.N(N)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .Q_LSB        (q_lsb),
`ifdef MULT_CTRL_ABORT_EN
    .abort        (abort),
`endif
    .mult_control (mult_control),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // operands and Q_LSB source
  logic [7:0] a_in = '0;
  logic [7:0] b_in = '0;
  bit         use_dp = 1'b1;
  logic [1:0] forced_q = 2'b00;

  // behavioural multiplicador: M, 9-bit HQ, LQ, Q_-1
  logic [7:0] m_reg = '0;
  logic [8:0] hq = '0;
  logic [7:0] lq = '0;
  logic       q_1 = 1'b0;
  logic [15:0] y;

  always @(posedge clk) begin
    if (mult_control[4]) m_reg <= a_in;
    if (mult_control[3]) begin
      lq  <= b_in;
      hq  <= '0;
      q_1 <= 1'b0;
    end
    if (mult_control[2])
      hq <= mult_control[0] ? hq + {m_reg[7], m_reg} : hq - {m_reg[7], m_reg};
    if (mult_control[1]) {hq, lq, q_1} <= {hq[8], hq, lq};
  end

  assign y     = {hq[7:0], lq};
  assign q_lsb = use_dp ? {lq[0], q_1} : forced_q;

  // expected trace: word = {mult_control, busy, done}
  logic [6:0]  exp_q[$];
  logic [6:0]  exp_cur = '0;
  logic [15:0] exp_prod = '0;

  task automatic build_trace();
    logic       op;
    logic [1:0] p;
    int         pa;
    int         pb;
    op = 1'b0;
    pa = $signed(a_in);
    pb = $signed(b_in);
    exp_prod = 16'(pa * pb);
    exp_q.push_back({5'b11000, 2'b10});
    for (int i = 0; i < N; i++) begin
      if (use_dp) p = {b_in[i], (i == 0) ? 1'b0 : b_in[i-1]};
      else p = forced_q;
      exp_q.push_back({4'b0000, op, 2'b10});
      if (p == 2'b01 || p == 2'b10) begin
        op = (p == 2'b01);
        exp_q.push_back({4'b0010, op, 2'b10});
      end
      exp_q.push_back({4'b0001, op, 2'b10});
    end
    exp_q.push_back({4'b0000, op, 2'b11});
  endtask

  initial begin
    forever begin
      @(posedge clk);
      if (!rst) begin
        exp_q.delete();
        exp_cur = '0;
      end
`ifdef MULT_CTRL_ABORT_EN
      else if (abort && exp_cur[1]) begin
        exp_q.delete();
        exp_cur = '0;
      end
`endif
      else if (exp_cur[1]) begin
        if (exp_q.size() > 0) exp_cur = exp_q.pop_front();
        else exp_cur = '0;
      end else if (start) begin
        build_trace();
        exp_cur = exp_q.pop_front();
      end
    end
  end

  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      chk("ctrl", {25'd0, mult_control, busy, done}, {25'd0, exp_cur});
      if (done && exp_cur[0] && use_dp) chk("prod", {16'd0, y}, {16'd0, exp_prod});
    end
  end

  task automatic run_meas(input logic [7:0] a, input logic [7:0] b,
                          input bit dp, input logic [1:0] q, input bit pulse,
                          output int lat, output int nld, output int nsh,
                          output int nadd, output int nas1, output int nd,
                          output logic [15:0] yd);
    a_in = a;
    b_in = b;
    use_dp = dp;
    forced_q = q;
    lat = -1; nld = 0; nsh = 0; nadd = 0; nas1 = 0; nd = 0; yd = '0;
    start = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (mult_control[4] && mult_control[3]) nld++;
      if (mult_control[1]) nsh++;
      if (mult_control[2]) begin
        nadd++;
        if (mult_control[0]) nas1++;
      end
      if (done) begin
        nd++;
        if (lat < 0) begin
          lat = k;
          yd = y;
        end
      end
      start = pulse && ((lat < 0 && k % 2 == 0) || k == lat);
      if (lat >= 0 && k >= lat + 3) break;
    end
    start = 1'b0;
    if (lat < 0) chk("timeout", 32'd0, 32'd1);
    @(negedge clk);
  endtask

  int lat, nld, nsh, nadd, nas1, nd, ns;
  logic [15:0] yd;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: no finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    start = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("reset_out", {29'd0, mult_control[4:3], busy, done}, 32'd0);
      chk("reset_ctl", {27'd0, mult_control}, 32'd0);
    end
    rst = 1'b1;
    start = 1'b0;
    @(negedge clk);

    run_meas(8'd5, 8'd0, 1'b0, 2'b00, 1'b0, lat, nld, nsh, nadd, nas1, nd, yd);
    chk("q00_lat", lat, 18);
    chk("q00_load", nld, 1);
    chk("q00_shift", nsh, 8);
    chk("q00_add", nadd, 0);

    run_meas(8'd5, 8'd0, 1'b0, 2'b01, 1'b0, lat, nld, nsh, nadd, nas1, nd, yd);
    chk("q01_lat", lat, 26);
    chk("q01_add", nadd, 8);
    chk("q01_as1", nas1, 8);
    chk("q01_shift", nsh, 8);

    run_meas(8'd5, 8'd0, 1'b0, 2'b10, 1'b0, lat, nld, nsh, nadd, nas1, nd, yd);
    chk("q10_lat", lat, 26);
    chk("q10_add", nadd, 8);
    chk("q10_as1", nas1, 0);

    run_meas(8'd19, 8'd12, 1'b1, 2'b00, 1'b0, lat, nld, nsh, nadd, nas1, nd, yd);
    chk("y_19x12", yd, 16'h00E4);
    chk("lat_19x12", lat, 20);

    run_meas(8'hE7, 8'd31, 1'b1, 2'b00, 1'b0, lat, nld, nsh, nadd, nas1, nd, yd);
    chk("y_m25x31", yd, 16'hFCF9);

    a_in = 8'd19;
    b_in = 8'd12;
    use_dp = 1'b1;
    start = 1'b1;
    ns = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (mult_control[1]) ns++;
      if (ns == 4) break;
    end
    chk("shift4_seen", ns, 4);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("midrst_out", {25'd0, mult_control, busy, done}, 32'd0);
    nd = 0;
    repeat (30) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("midrst_nodone", nd, 0);

    run_meas(8'd19, 8'd12, 1'b1, 2'b00, 1'b1, lat, nld, nsh, nadd, nas1, nd, yd);
    chk("after_rst_y", yd, 16'h00E4);
    chk("busy_start_done", nd, 1);

`ifdef MULT_CTRL_ABORT_EN
    use_dp = 1'b0;
    forced_q = 2'b01;
    start = 1'b1;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (mult_control[2]) break;
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    nd = 0;
    repeat (10) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("abort_nodone", nd, 0);
    run_meas(8'd19, 8'd12, 1'b1, 2'b00, 1'b0, lat, nld, nsh, nadd, nas1, nd, yd);
    chk("abort_then_y", yd, 16'h00E4);
`endif

    for (int r = 0; r < 40; r++) begin
      logic [7:0] ra;
      logic [7:0] rb;
      bit         rdp;
      ra = 8'($urandom);
      rb = 8'($urandom);
      rdp = ($urandom_range(0, 4) != 0);
      run_meas(ra, rb, rdp, 2'($urandom), 1'($urandom), lat, nld, nsh, nadd,
               nas1, nd, yd);
      chk("rand_one_done", nd, 1);
      chk("rand_shifts", nsh, N);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
